alu_arbiter: RTL and testbench

Two-port round-robin arbiter that time-shares the single combinational `alu` (ctl/a/b → out/zero) between two requesters, e.g. the EX-stage datapath (port 0) and the branch-compare/address unit (port 1). It accepts at most one operation per cycle through a valid/ready handshake and registers the ALU operands and result in a 2-stage pipeline. It returns each result, with its tag, to the port that issued it. The `alu` itself is instantiated outside this block and wired to the `alu_*` ports.

---
 rtl/alu_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin arbiter sharing one external combinational ALU
//
// Purpose:
//   Time-shares a single external combinational ALU between two requesters.
//   One operation is accepted per cycle through a valid/ready handshake.
//   The accepted operation is registered into S1, which drives the ALU. The
//   ALU result is registered into S2, which produces a one-cycle response
//   pulse on the port that issued the operation, with its tag echoed back.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   req{0,1}_valid/ready        request handshake per port
//   req{0,1}_ctl/a/b/tag        ALU opcode, operands and requester tag
//   rsp{0,1}_valid              one-cycle result pulse, no backpressure
//   rsp{0,1}_out/zero/err/tag   result, zero flag, illegal-op flag, tag
//   alu_ctl/alu_a/alu_b         to the external ALU
//   alu_out/alu_zero            from the external ALU

module alu_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_ctl,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_ctl,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,

  output logic             rsp0_valid,
  output logic [31:0]      rsp0_out,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  output logic [TAG_W-1:0] rsp0_tag,

  output logic             rsp1_valid,
  output logic [31:0]      rsp1_out,
  output logic             rsp1_zero,
  output logic             rsp1_err,
  output logic [TAG_W-1:0] rsp1_tag,

  output logic [3:0]       alu_ctl,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_out,
  input  logic             alu_zero
);

  // Opcodes the ALU implements; anything else is answered with err=1.
  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;

  // Port that won the most recent accept; reset to 1 so port 0 wins the
  // first contention.
  logic             last;

  logic             grant0;
  logic             grant1;
  logic             accept;

  logic [3:0]       sel_ctl;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [TAG_W-1:0] sel_tag;

  logic             s1_valid;
  logic             s1_port;
  logic [3:0]       s1_ctl;
  logic [31:0]      s1_a;
  logic [31:0]      s1_b;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_legal;

  logic             s2_valid;
  logic             s2_port;
  logic [31:0]      s2_out;
  logic             s2_zero;
  logic             s2_err;
  logic [TAG_W-1:0] s2_tag;

  // Arbitration: a lone requester always wins; under contention the port
  // that did not win last time is granted. Grants are mutually exclusive
  // by construction and suppressed entirely while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n) begin
      if (req0_valid && (!req1_valid || last)) begin
        grant0 = 1'b1;
      end else if (req1_valid && (!req0_valid || !last)) begin
        grant1 = 1'b1;
      end
    end
  end

  assign accept     = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Request mux feeding S1.
  always_comb begin
    sel_ctl = req0_ctl;
    sel_a   = req0_a;
    sel_b   = req0_b;
    sel_tag = req0_tag;
    if (grant1) begin
      sel_ctl = req1_ctl;
      sel_a   = req1_a;
      sel_b   = req1_b;
      sel_tag = req1_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= grant1;
    end
  end

  // S1: data registers only load on accept, so the ALU inputs stay quiet
  // between operations.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_port  <= 1'b0;
      s1_ctl   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_port <= grant1;
        s1_ctl  <= sel_ctl;
        s1_a    <= sel_a;
        s1_b    <= sel_b;
        s1_tag  <= sel_tag;
      end
    end
  end

  assign alu_ctl = s1_ctl;
  assign alu_a   = s1_a;
  assign alu_b   = s1_b;

  always_comb begin
    s1_legal = 1'b0;
    case (s1_ctl)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: s1_legal = 1'b1;
      default:                               s1_legal = 1'b0;
    endcase
  end

  // S2: captures the ALU result every cycle. Illegal ops still flow through
  // so the requester gets an answer, but with result and zero flag cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_port  <= 1'b0;
      s2_out   <= '0;
      s2_zero  <= 1'b0;
      s2_err   <= 1'b0;
      s2_tag   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_port  <= s1_port;
      s2_tag   <= s1_tag;
      s2_err   <= !s1_legal;
      s2_out   <= s1_legal ? alu_out : 32'd0;
      s2_zero  <= s1_legal ? alu_zero : 1'b0;
    end
  end

  // Response routing: data buses are shared, only the valid is steered.
  assign rsp0_valid = s2_valid & (s2_port == 1'b0);
  assign rsp1_valid = s2_valid & (s2_port == 1'b1);

  assign rsp0_out  = s2_out;
  assign rsp0_zero = s2_zero;
  assign rsp0_err  = s2_err;
  assign rsp0_tag  = s2_tag;

  assign rsp1_out  = s2_out;
  assign rsp1_zero = s2_zero;
  assign rsp1_err  = s2_err;
  assign rsp1_tag  = s2_tag;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with an external ALU model

module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_ctl, req1_ctl;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_tag, req1_tag;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_out, rsp1_out;
  logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
  logic [3:0]  rsp0_tag, rsp1_tag;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_zero;

  alu_arbiter #(.TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl),
    .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl),
    .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_out(rsp0_out), .rsp0_zero(rsp0_zero),
    .rsp0_err(rsp0_err), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_out(rsp1_out), .rsp1_zero(rsp1_zero),
    .rsp1_err(rsp1_err), .rsp1_tag(rsp1_tag),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  // External ALU. Undefined opcodes return a^b so masking by the arbiter
  // is observable.
  always_comb begin
    case (alu_ctl)
      4'd0:    alu_out = alu_a & alu_b;
      4'd1:    alu_out = alu_a | alu_b;
      4'd2:    alu_out = alu_a + alu_b;
      4'd6:    alu_out = alu_a - alu_b;
      4'd7:    alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_out = alu_a ^ alu_b;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic issue(input logic p, input logic [3:0] ctl, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    if (!p) begin
      req0_valid = 1'b1; req0_ctl = ctl; req0_a = a; req0_b = b; req0_tag = tag;
    end else begin
      req1_valid = 1'b1; req1_ctl = ctl; req1_a = a; req1_b = b; req1_tag = tag;
    end
  endtask

  task automatic chk_idle(input string nm);
    chk1({nm, " rsp0_valid"}, rsp0_valid, 1'b0);
    chk1({nm, " rsp1_valid"}, rsp1_valid, 1'b0);
  endtask

  task automatic chk_rsp(input string nm, input logic p, input logic [31:0] out,
                         input logic zero, input logic err, input logic [3:0] tag);
    chk1({nm, " rsp0_valid"}, rsp0_valid, !p);
    chk1({nm, " rsp1_valid"}, rsp1_valid, p);
    chk32({nm, " out"}, p ? rsp1_out : rsp0_out, out);
    chk1({nm, " zero"}, p ? rsp1_zero : rsp0_zero, zero);
    chk1({nm, " err"}, p ? rsp1_err : rsp0_err, err);
    chk32({nm, " tag"}, 32'(p ? rsp1_tag : rsp0_tag), 32'(tag));
  endtask

  // Reference model: expected result straight from the opcode table.
  typedef struct {
    int          due;
    logic        port;
    logic [31:0] out;
    logic        zero;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  function automatic exp_t model_op(input logic p, input logic [3:0] ctl, input logic [31:0] a,
                                    input logic [31:0] b, input logic [3:0] tag);
    exp_t e;
    logic [31:0] r;
    logic legal;
    legal = 1'b1;
    r = 32'd0;
    if      (ctl == 4'd0) r = a & b;
    else if (ctl == 4'd1) r = a | b;
    else if (ctl == 4'd2) r = a + b;
    else if (ctl == 4'd6) r = a - b;
    else if (ctl == 4'd7) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    else legal = 1'b0;
    e.due  = 0;
    e.port = p;
    e.out  = legal ? r : 32'd0;
    e.zero = legal && (r == 32'd0);
    e.err  = !legal;
    e.tag  = tag;
    return e;
  endfunction

  function automatic logic [3:0] rand_ctl();
    logic [3:0] c;
    case ($urandom_range(0, 5))
      0: c = 4'd0;
      1: c = 4'd1;
      2: c = 4'd2;
      3: c = 4'd6;
      4: c = 4'd7;
      default: c = 4'($urandom_range(0, 15));
    endcase
    return c;
  endfunction

  typedef struct {
    logic        port;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp_out;
    logic        exp_zero;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  exp_t q[$];
  exp_t e;
  logic        pv[2];
  logic [3:0]  pctl[2];
  logic [31:0] pa[2];
  logic [31:0] pb[2];
  logic [3:0]  ptag[2];
  logic        m_last, g0, g1, gp;
  int          cyc;

  initial begin
    vecs[0]  = '{1'b0, 4'd0, 32'd32,        32'd96,  4'd3,  32'd32, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd1, 32'd32,        32'd64,  4'd5,  32'd96, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'd2, 32'd32,        32'd64,  4'd6,  32'd96, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'd6, 32'd64,        32'd32,  4'd1,  32'd32, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'd7, 32'd64,        32'd3,   4'd2,  32'd0,  1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'd5, 32'd1,         32'd1,   4'd9,  32'd0,  1'b0, 1'b1};
    vecs[6]  = '{1'b0, 4'd6, 32'd5,         32'd5,   4'd10, 32'd0,  1'b1, 1'b0};
    vecs[7]  = '{1'b1, 4'd7, 32'd3,         32'd64,  4'd11, 32'd1,  1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'd7, 32'hffff_ffff, 32'd1,   4'd12, 32'd1,  1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'd15, 32'd7,        32'd9,   4'd13, 32'd0,  1'b0, 1'b1};
    vecs[10] = '{1'b0, 4'd2, 32'hffff_ffff, 32'd1,   4'd14, 32'd0,  1'b1, 1'b0};

    // Reset: readies forced low even with requests present; outputs zeroed.
    rst_n = 1'b0;
    issue(1'b0, 4'd2, 32'd1, 32'd2, 4'd1);
    issue(1'b1, 4'd2, 32'd3, 32'd4, 4'd2);
    @(negedge clk);
    #1;
    chk1("reset ready0", req0_ready, 1'b0);
    chk1("reset ready1", req1_ready, 1'b0);
    tick();
    chk_idle("reset");
    chk32("reset alu_ctl", 32'(alu_ctl), 32'd0);
    chk32("reset alu_a", alu_a, 32'd0);
    chk32("reset alu_b", alu_b, 32'd0);
    chk32("reset rsp0_out", rsp0_out, 32'd0);
    chk32("reset rsp1_out", rsp1_out, 32'd0);
    chk1("reset rsp0_zero", rsp0_zero, 1'b0);
    chk1("reset rsp0_err", rsp0_err, 1'b0);
    chk32("reset rsp0_tag", 32'(rsp0_tag), 32'd0);
    clear_reqs();
    rst_n = 1'b1;
    tick();

    // Single operations from idle: latency two edges, one-cycle pulse.
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].port, vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].tag);
      #1;
      chk1($sformatf("vec%0d ready0", i), req0_ready, !vecs[i].port);
      chk1($sformatf("vec%0d ready1", i), req1_ready, vecs[i].port);
      tick();
      clear_reqs();
      chk_idle($sformatf("vec%0d early", i));
      tick();
      chk_rsp($sformatf("vec%0d", i), vecs[i].port, vecs[i].exp_out, vecs[i].exp_zero,
              vecs[i].exp_err, vecs[i].tag);
      tick();
      chk_idle($sformatf("vec%0d after", i));
    end

    // Port 1 back-to-back: pulses on consecutive cycles.
    issue(1'b1, 4'd1, 32'd32, 32'd64, 4'd4);
    #1;
    chk1("b2b ready1 first", req1_ready, 1'b1);
    tick();
    issue(1'b1, 4'd2, 32'd32, 32'd64, 4'd8);
    #1;
    chk1("b2b ready1 second", req1_ready, 1'b1);
    tick();
    clear_reqs();
    chk_rsp("b2b or", 1'b1, 32'd96, 1'b0, 1'b0, 4'd4);
    tick();
    chk_rsp("b2b add", 1'b1, 32'd96, 1'b0, 1'b0, 4'd8);
    tick();
    chk_idle("b2b after");

    // Contention from reset: grants alternate 0,1,0,1; port 1 waits with
    // stable operands on the first cycle.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        issue(1'b0, 4'd6, 32'd64, 32'd32, 4'd1);
        issue(1'b1, 4'd7, 32'd64, 32'd3, 4'd2);
      end else begin
        clear_reqs();
      end
      #1;
      if (k < 4) begin
        chk1($sformatf("cont%0d ready0", k), req0_ready, (k % 2) == 0);
        chk1($sformatf("cont%0d ready1", k), req1_ready, (k % 2) == 1);
      end
      if (k >= 2) begin
        if ((k % 2) == 0) chk_rsp($sformatf("cont%0d sub", k), 1'b0, 32'd32, 1'b0, 1'b0, 4'd1);
        else              chk_rsp($sformatf("cont%0d slt", k), 1'b1, 32'd0, 1'b1, 1'b0, 4'd2);
      end else begin
        chk_idle($sformatf("cont%0d", k));
      end
      tick();
    end
    chk_idle("cont drained");

    // Reset while an op is in flight: no response, last returns to 1.
    issue(1'b0, 4'd2, 32'd1, 32'd2, 4'd7);
    #1;
    chk1("flight ready0", req0_ready, 1'b1);
    tick();
    clear_reqs();
    rst_n = 1'b0;
    tick();
    chk_idle("flight reset");
    chk32("flight rsp0_out", rsp0_out, 32'd0);
    chk32("flight rsp0_tag", 32'(rsp0_tag), 32'd0);
    chk32("flight alu_a", alu_a, 32'd0);
    chk32("flight alu_b", alu_b, 32'd0);
    chk32("flight alu_ctl", 32'(alu_ctl), 32'd0);
    issue(1'b0, 4'd0, 32'd1, 32'd1, 4'd1);
    issue(1'b1, 4'd0, 32'd1, 32'd1, 4'd2);
    #1;
    chk1("flight rst ready0", req0_ready, 1'b0);
    chk1("flight rst ready1", req1_ready, 1'b0);
    tick();
    rst_n = 1'b1;
    clear_reqs();
    tick();
    chk_idle("flight released");
    issue(1'b0, 4'd0, 32'd1, 32'd1, 4'd1);
    issue(1'b1, 4'd0, 32'd1, 32'd1, 4'd2);
    #1;
    chk1("flight first ready0", req0_ready, 1'b1);
    chk1("flight first ready1", req1_ready, 1'b0);
    clear_reqs();
    tick();

    // Randomized traffic against the queue-based reference model.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_last = 1'b1;
    q.delete();
    cyc = 0;
    for (int p = 0; p < 2; p++) pv[p] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk_rsp($sformatf("rand c%0d", c), e.port, e.out, e.zero, e.err, e.tag);
      end else begin
        chk_idle($sformatf("rand c%0d", c));
      end
      rst_n = ($urandom_range(0, 63) != 0);
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 3) != 0) begin
          pv[p]   = 1'b1;
          pctl[p] = rand_ctl();
          pa[p]   = $urandom();
          pb[p]   = ($urandom_range(0, 3) == 0) ? pa[p] : $urandom();
          ptag[p] = 4'($urandom_range(0, 15));
        end
      end
      req0_valid = pv[0]; req0_ctl = pctl[0]; req0_a = pa[0]; req0_b = pb[0]; req0_tag = ptag[0];
      req1_valid = pv[1]; req1_ctl = pctl[1]; req1_a = pa[1]; req1_b = pb[1]; req1_tag = ptag[1];
      #1;
      g0 = 1'b0;
      g1 = 1'b0;
      if (rst_n) begin
        if (pv[0] && pv[1]) begin
          if (m_last) g0 = 1'b1;
          else        g1 = 1'b1;
        end else begin
          g0 = pv[0];
          g1 = pv[1];
        end
      end
      chk1($sformatf("rand c%0d ready0", c), req0_ready, g0);
      chk1($sformatf("rand c%0d ready1", c), req1_ready, g1);
      if (g0 || g1) begin
        gp = g1;
        e = model_op(gp, pctl[gp], pa[gp], pb[gp], ptag[gp]);
        e.due = cyc + 2;
        q.push_back(e);
        m_last = gp;
        pv[gp] = 1'b0;
      end
      if (!rst_n) begin
        q.delete();
        m_last = 1'b1;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
